// File: rtl/comp_subtractor_seq_if.sv
// Request/result bundle for comp_subtractor_seq.
//   start/r/a/b : operation request (driven by master)
//   busy/done   : progress and one-cycle completion pulse (driven by slave)
//   y/neg/err   : signed-magnitude result and invalid-BCD flag (driven by slave)
interface comp_subtractor_seq_if #(
    parameter int unsigned NDIG = 4
);
    localparam int unsigned W = 4 * NDIG;

    logic         start;
    logic         r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         neg;
    logic         err;

    modport master (output start, r, a, b, input busy, done, y, neg, err);
    modport slave  (input start, r, a, b, output busy, done, y, neg, err);
endinterface

// File: rtl/comp_subtractor_seq.sv
// Digit-serial complement subtractor: y = |A - B| with sign in neg.
// Adds A to the 9's (r=1, BCD) or 1's (r=0, binary) complement of B one digit
// per cycle, then either applies end-around carry (+1) or recomplements.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of comp_subtractor_seq_if (start/r/a/b in,
//                busy/done/y/neg/err out, all outputs registered)
module comp_subtractor_seq #(
    parameter int unsigned NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comp_subtractor_seq_if.slave  bus
);
    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
    logic          r_q, r_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          c_q, c_d;        // running digit carry
    logic          cend_q, cend_d;  // final ADD carry: 1 = positive result
    logic          busy_q, busy_d, done_q, done_d, neg_q, neg_d, err_q, err_d;

    logic [3:0] a_dig, b_dig, y_dig, comp_b, dig_new;
    logic [4:0] sum;
    logic       carry_new, last;

    // Any nibble above 9 is not a BCD digit.
    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        r_d     = r_q;
        idx_d   = idx_q;
        c_d     = c_q;
        cend_d  = cend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        err_d   = err_q;

        a_dig = 4'd0;
        b_dig = 4'd0;
        y_dig = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[i*4 +: 4];
                b_dig = b_q[i*4 +: 4];
                y_dig = y_q[i*4 +: 4];
            end
        end
        last      = (idx_q == IW'(NDIG - 1));
        comp_b    = r_q ? (4'd9 - b_dig) : ~b_dig;
        sum       = 5'd0;
        dig_new   = 4'd0;
        carry_new = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    r_d   = bus.r;
                    idx_d = '0;
                    c_d   = 1'b0;
                    y_d   = '0;
                    neg_d = 1'b0;
                    if (bus.r && (has_bad(bus.a) || has_bad(bus.b))) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_ADD;
                    end
                end
            end

            S_ADD: begin
                sum = {1'b0, a_dig} + {1'b0, comp_b} + {4'd0, c_q};
                if (r_q) begin
                    carry_new = (sum > 5'd9);
                    dig_new   = carry_new ? 4'(sum - 5'd10) : sum[3:0];
                end else begin
                    carry_new = sum[4];
                    dig_new   = sum[3:0];
                end
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IW'(i)) y_d[i*4 +: 4] = dig_new;
                end
                if (last) begin
                    cend_d  = carry_new;
                    c_d     = 1'b1;  // seeds the end-around +1
                    idx_d   = '0;
                    state_d = S_FIX;
                end else begin
                    c_d   = carry_new;
                    idx_d = idx_q + IW'(1);
                end
            end

            S_FIX: begin
                if (cend_q) begin
                    sum = {1'b0, y_dig} + {4'd0, c_q};
                    if (r_q) begin
                        carry_new = (sum > 5'd9);
                        dig_new   = carry_new ? 4'd0 : sum[3:0];
                    end else begin
                        carry_new = sum[4];
                        dig_new   = sum[3:0];
                    end
                end else begin
                    dig_new = r_q ? (4'd9 - y_dig) : ~y_dig;
                end
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IW'(i)) y_d[i*4 +: 4] = dig_new;
                end
                c_d = carry_new;
                if (last) begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Equal operands recomplement to zero; never report -0.
                    neg_d   = !cend_q && (y_d != '0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            r_q     <= 1'b0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            cend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            cend_q  <= cend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;
endmodule
